// File: rtl/uart_cmd_queue_if.sv
// Byte/tick inputs and game-control outputs between the UART side and the snake core.
// master drives the received bytes and ticks; slave is the command queue.
interface uart_cmd_queue_if #(
  parameter int DEPTH = 4
);
  logic                     i_wr;
  logic [7:0]               i_data;
  logic                     i_tick;
  logic [1:0]               o_dir;
  logic                     o_pause;
  logic                     o_restart;
  logic [$clog2(DEPTH):0]   o_level;
  logic                     o_overflow;

  modport master (
    output i_wr, i_data, i_tick,
    input  o_dir, o_pause, o_restart, o_level, o_overflow
  );

  modport slave (
    input  i_wr, i_data, i_tick,
    output o_dir, o_pause, o_restart, o_level, o_overflow
  );
endinterface

// File: rtl/uart_cmd_queue.sv
// Decodes UART key bytes into snake direction commands and queues them in a small FIFO.
// The FIFO is popped once per movement tick; it also provides pause and restart controls.
module uart_cmd_queue #(
  parameter int         DEPTH    = 4,
  parameter logic [1:0] INIT_DIR = 2'b01
) (
  input  logic           clk,
  input  logic           rstn,
  uart_cmd_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [1:0]    dir_reg, tail_reg;
  logic          pause_reg, restart_reg, overflow_reg;

  logic [7:0] key_lc;
  logic       is_dir, is_pause, is_restart;
  logic [1:0] cmd;
  logic       legal, do_pop, do_push, do_drop;

  // Folding bit 5 in makes letter matching case-insensitive; only the two cases of each letter map.
  always_comb begin
    key_lc     = bus.i_data | 8'h20;
    is_dir     = 1'b0;
    is_pause   = 1'b0;
    is_restart = 1'b0;
    cmd        = 2'b00;
    if (bus.i_wr) begin
      case (key_lc)
        8'h77:   begin is_dir = 1'b1; cmd = 2'b00; end
        8'h64:   begin is_dir = 1'b1; cmd = 2'b01; end
        8'h73:   begin is_dir = 1'b1; cmd = 2'b10; end
        8'h61:   begin is_dir = 1'b1; cmd = 2'b11; end
        8'h70:   is_pause   = 1'b1;
        8'h72:   is_restart = 1'b1;
        default: ;
      endcase
    end
  end

  // Pop decisions use pre-push state, so a push into an empty queue is never bypassed to o_dir.
  always_comb begin
    legal   = is_dir && (cmd != tail_reg) && (cmd != (tail_reg ^ 2'b10));
    do_pop  = bus.i_tick && !pause_reg && (level_reg != '0) && !is_restart;
    do_push = legal && ((level_reg != FULL_LEVEL) || do_pop);
    do_drop = legal && (level_reg == FULL_LEVEL) && !do_pop;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= cmd;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      level_reg    <= '0;
      dir_reg      <= INIT_DIR;
      tail_reg     <= INIT_DIR;
      pause_reg    <= 1'b0;
      restart_reg  <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      restart_reg <= is_restart;
      if (is_restart) begin
        rd_ptr_reg   <= '0;
        wr_ptr_reg   <= '0;
        level_reg    <= '0;
        dir_reg      <= INIT_DIR;
        tail_reg     <= INIT_DIR;
        pause_reg    <= 1'b0;
        overflow_reg <= 1'b0;
      end else begin
        if (do_pop) begin
          dir_reg    <= mem[rd_ptr_reg];
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        if (do_push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
          tail_reg   <= cmd;
        end
        case ({do_push, do_pop})
          2'b10:   level_reg <= level_reg + 1'b1;
          2'b01:   level_reg <= level_reg - 1'b1;
          default: ;
        endcase
        if (do_drop) begin
          overflow_reg <= 1'b1;
        end
        if (is_pause) begin
          pause_reg <= ~pause_reg;
        end
      end
    end
  end

  assign bus.o_dir      = dir_reg;
  assign bus.o_pause    = pause_reg;
  assign bus.o_restart  = restart_reg;
  assign bus.o_level    = level_reg;
  assign bus.o_overflow = overflow_reg;
endmodule

// File: tb/tb_uart_cmd_queue.sv
// Directed bench for uart_cmd_queue: key decoding, accept rule, FIFO order, pause, restart, reset.
module tb_uart_cmd_queue;
  logic clk;
  logic rstn;
  int   checks = 0;
  int   fails  = 0;

  uart_cmd_queue_if #(.DEPTH(4)) bus ();

  uart_cmd_queue #(.DEPTH(4), .INIT_DIR(2'b01)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus between falling edges; outputs are checked at the following negedge.
  task automatic step(input logic wr, input logic [7:0] data, input logic tick);
    @(negedge clk);
    bus.i_wr   = wr;
    bus.i_data = data;
    bus.i_tick = tick;
    @(negedge clk);
    bus.i_wr   = 1'b0;
    bus.i_data = 8'h00;
    bus.i_tick = 1'b0;
    $display("step wr=%0b data=%02h tick=%0b -> dir=%0d level=%0d pause=%0b ovf=%0b rst=%0b",
             wr, data, tick, bus.o_dir, bus.o_level, bus.o_pause, bus.o_overflow, bus.o_restart);
  endtask

  task automatic key(input logic [7:0] data);
    step(1'b1, data, 1'b0);
  endtask

  task automatic tick();
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic chk_state(input string tag, input logic [1:0] dir, input logic [2:0] level,
                           input logic ovf);
    chk({tag, "_dir"}, 8'(bus.o_dir), 8'(dir));
    chk({tag, "_level"}, 8'(bus.o_level), 8'(level));
    chk({tag, "_ovf"}, 8'(bus.o_overflow), 8'(ovf));
  endtask

  initial begin
    rstn       = 1'b0;
    bus.i_wr   = 1'b0;
    bus.i_data = 8'h00;
    bus.i_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk_state("reset", 2'b01, 3'd0, 1'b0);
    chk("reset_pause", 8'(bus.o_pause), 8'd0);
    chk("reset_restart", 8'(bus.o_restart), 8'd0);
    rstn = 1'b1;

    // Single command through the queue
    key("w");
    chk_state("t1_push", 2'b01, 3'd1, 1'b0);
    tick();
    chk_state("t1_pop", 2'b00, 3'd0, 1'b0);

    // Get back to RIGHT, then reversal and repeat are rejected
    key("d");
    tick();
    chk_state("t2_right", 2'b01, 3'd0, 1'b0);
    key("a");
    chk_state("t2_reverse", 2'b01, 3'd0, 1'b0);
    key("D");
    chk_state("t2_repeat", 2'b01, 3'd0, 1'b0);
    key("x");
    chk_state("t2_ignored", 2'b01, 3'd0, 1'b0);

    // Fill to DEPTH, fifth command dropped, drain in order
    key("w"); key("d"); key("s"); key("a");
    chk_state("t3_full", 2'b01, 3'd4, 1'b0);
    key("w");
    chk_state("t3_drop", 2'b01, 3'd4, 1'b1);
    tick(); chk("t3_pop0", 8'(bus.o_dir), 8'd0);
    tick(); chk("t3_pop1", 8'(bus.o_dir), 8'd1);
    tick(); chk("t3_pop2", 8'(bus.o_dir), 8'd2);
    tick(); chk("t3_pop3", 8'(bus.o_dir), 8'd3);
    chk("t3_empty", 8'(bus.o_level), 8'd0);

    // Pause: keys still queue, ticks ignored
    key("P");
    chk("t4_paused", 8'(bus.o_pause), 8'd1);
    key("s");
    tick();
    chk_state("t4_tick_paused", 2'b11, 3'd1, 1'b1);
    key("p");
    chk("t4_unpaused", 8'(bus.o_pause), 8'd0);
    tick();
    chk_state("t4_pop", 2'b10, 3'd0, 1'b1);

    // Restart flushes and pulses for one cycle
    key("a"); key("w"); key("d"); key("s"); key("a");
    chk_state("t5_full_ovf", 2'b10, 3'd4, 1'b1);
    key("R");
    chk_state("t5_restart", 2'b01, 3'd0, 1'b0);
    chk("t5_pulse_hi", 8'(bus.o_restart), 8'd1);
    chk("t5_pause", 8'(bus.o_pause), 8'd0);
    @(negedge clk);
    chk("t5_pulse_lo", 8'(bus.o_restart), 8'd0);

    // Coincident byte and tick, empty queue: tick does nothing, byte queued
    step(1'b1, "s", 1'b1);
    chk_state("t6_empty_coinc", 2'b01, 3'd1, 1'b0);
    tick();
    chk_state("t6_drain", 2'b10, 3'd0, 1'b0);

    // Full queue: pop happens, illegal push rejected, then legal push at full
    key("a"); key("w"); key("d"); key("s");
    chk_state("t6_full", 2'b10, 3'd4, 1'b0);
    step(1'b1, "s", 1'b1);
    chk_state("t6_full_repeat", 2'b11, 3'd3, 1'b0);
    key("a");
    step(1'b1, "w", 1'b1);
    chk_state("t6_full_coinc", 2'b00, 3'd4, 1'b0);

    // Async reset mid-operation, applied away from a clock edge
    #2 rstn = 1'b0;
    #1;
    chk_state("async_reset", 2'b01, 3'd0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
